// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package pll_seq_pkg;

   typedef enum logic [1:0] {
      RESET_PLL = 2'd0,
      WAIT_LOCK = 2'd1,
      STABLE    = 2'd2,
      RUN       = 2'd3
   } seq_state_t;

   // Saturation point of the lock-timeout counter.
   localparam int RETRY_MAX = 15;

   // Bits needed to hold the largest counter load value, max(a,b,c)-1.
   function automatic int cnt_width(int a, int b, int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return (m <= 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/pll_seq_sync.sv
// Two-flop synchroniser bringing an asynchronous level into the local clock domain.
// Latency: 2 clk edges from a stable input to the output.
// Backpressure: none; a level is sampled every cycle.
module pll_seq_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);

   logic meta;

   // First flop may go metastable; the second gives it a full cycle to settle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         dout <= 1'b0;
      end else begin
         meta <= din;
         dout <= meta;
      end
   end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Pulses the PLL reset, waits for lock with timeout/retry, debounces lock, then releases sys_rst_n.
// Latency: lock rise to sys_rst_n high is 3 + STABLE_CYCLES edges; lock loss in RUN to reset is 3 edges.
// Backpressure: none; req_reset and clr_status are levels/pulses sampled every refclk cycle.
module pll_reset_sequencer
   import pll_seq_pkg::*;
#(
   parameter int RST_CYCLES    = 32,
   parameter int LOCK_TIMEOUT  = 500000,
   parameter int STABLE_CYCLES = 1024,
   parameter int CNT_W         = 20
) (
   input  logic       refclk,
   input  logic       rst_n,
   input  logic       pll_locked,
   input  logic       req_reset,
   input  logic       clr_status,
   output logic       pll_rst,
   output logic       sys_rst_n,
   output logic       ready,
   output logic [3:0] retry_count,
   output logic       lock_lost
);

   localparam int CNT_REQ = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

   if (CNT_W < CNT_REQ) begin : g_cnt_w_check
      $error("pll_reset_sequencer: CNT_W too small for the largest counter load");
   end

   localparam logic [CNT_W-1:0] RST_LOAD     = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STABLE_LOAD  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
   localparam logic [3:0]       RETRY_SAT    = 4'(RETRY_MAX);

   seq_state_t       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             locked_s;
   logic             retry_inc;
   logic             lost_set;

   pll_seq_sync u_lock_sync (
      .clk   (refclk),
      .rst_n (rst_n),
      .din   (pll_locked),
      .dout  (locked_s)
   );

   // Next state and shared counter; each state reloads the counter on entry.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = (cnt != '0) ? (cnt - CNT_ONE) : cnt;
      retry_inc = 1'b0;
      lost_set  = 1'b0;
      case (state)
         RESET_PLL: begin
            if (cnt == '0) begin
               state_nxt = WAIT_LOCK;
               cnt_nxt   = TIMEOUT_LOAD;
            end
         end
         WAIT_LOCK: begin
            if (locked_s) begin
               state_nxt = STABLE;
               cnt_nxt   = STABLE_LOAD;
            end else if (cnt == '0) begin
               state_nxt = RESET_PLL;
               cnt_nxt   = RST_LOAD;
               retry_inc = 1'b1;
            end
         end
         STABLE: begin
            // A glitch restarts the lock wait with a fresh timeout, not a retry.
            if (!locked_s) begin
               state_nxt = WAIT_LOCK;
               cnt_nxt   = TIMEOUT_LOAD;
            end else if (cnt == '0) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (!locked_s) begin
               state_nxt = RESET_PLL;
               cnt_nxt   = RST_LOAD;
               lost_set  = 1'b1;
            end
         end
         default: begin
            state_nxt = RESET_PLL;
            cnt_nxt   = RST_LOAD;
         end
      endcase
      // Soft reset overrides every transition; a coincident lock drop still flags lock_lost.
      if (req_reset) begin
         state_nxt = RESET_PLL;
         cnt_nxt   = RST_LOAD;
         retry_inc = 1'b0;
      end
   end

   // State, counter and registered output decodes, all updated on the same edge.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RESET_PLL;
         cnt       <= RST_LOAD;
         pll_rst   <= 1'b1;
         sys_rst_n <= 1'b0;
         ready     <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         pll_rst   <= (state_nxt == RESET_PLL);
         sys_rst_n <= (state_nxt == RUN);
         ready     <= (state_nxt == RUN);
      end
   end

   // Status: saturating timeout count and sticky lock-lost flag (set beats clear).
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         retry_count <= 4'd0;
         lock_lost   <= 1'b0;
      end else begin
         if (retry_inc && (retry_count != RETRY_SAT)) begin
            retry_count <= retry_count + 4'd1;
         end
         if (lost_set) begin
            lock_lost <= 1'b1;
         end else if (clr_status) begin
            lock_lost <= 1'b0;
         end
      end
   end

endmodule
